// File: rtl/up_counter_if.sv
// up_counter_if: bus between a free-running up counter, its duty source and the step monitor
interface up_counter_if #(
  parameter int CNT_W  = 4,
  parameter int WRAP_W = 8
);
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  duty_in;
  logic              duty_load;
  logic              err_clear;
  logic              pwm_out;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              step_error;
  logic [CNT_W-1:0]  err_value;
  logic [CNT_W-1:0]  err_expected;
  modport master (
    output counter, duty_in, duty_load, err_clear,
    input  pwm_out, wrap_pulse, wrap_count, step_error, err_value, err_expected
  );
  modport slave (
    input  counter, duty_in, duty_load, err_clear,
    output pwm_out, wrap_pulse, wrap_count, step_error, err_value, err_expected
  );
endinterface

// File: rtl/up_counter_monitor.sv
// up_counter_monitor: checks +1 mod 2^CNT_W stepping, tallies wraps, drives wrap-aligned PWM, latches first fault
module up_counter_monitor #(
  parameter int CNT_W      = 4,
  parameter int WRAP_W     = 8,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input logic        clk,
  input logic        reset,
  up_counter_if.slave bus
);
  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = 1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic [CNT_W-1:0]  duty_act_q, duty_act_d;
  logic [CNT_W-1:0]  duty_pend_q, duty_pend_d;
  logic [CNT_W-1:0]  err_val_q, err_val_d;
  logic [CNT_W-1:0]  err_exp_q, err_exp_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              pwm_q, pwm_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  expected;
  logic              live, step_ok, hold_ok, wrap_det, fault;
  // err_clear pre-empts any decision taken in TRACK on the same edge
  assign live     = (state_q == TRACK) && !bus.err_clear;
  assign expected = prev_q + CNT_ONE;
  assign step_ok  = bus.counter == expected;
  assign hold_ok  = ALLOW_HOLD && (bus.counter == prev_q);
  assign wrap_det = live && step_ok && (prev_q == CNT_MAX);
  assign fault    = live && !step_ok && !hold_ok;
  always_comb begin
    state_d     = bus.err_clear ? SYNC : (state_q == SYNC) ? TRACK : fault ? FAULT : state_q;
    prev_d      = ((state_q == SYNC) || (live && step_ok)) ? bus.counter : prev_q;
    duty_pend_d = bus.duty_load ? bus.duty_in : duty_pend_q;
    duty_act_d  = wrap_det ? duty_pend_q : duty_act_q;
    pwm_d       = live && !fault && (bus.counter < duty_act_d);
    wrap_d      = wrap_det;
    wrap_cnt_d  = bus.err_clear ? '0 : (wrap_det && wrap_cnt_q != WRAP_MAX) ? wrap_cnt_q + WRAP_ONE : wrap_cnt_q;
    err_d       = !bus.err_clear && (err_q || fault);
    err_val_d   = fault ? bus.counter : err_val_q;
    err_exp_d   = fault ? expected : err_exp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      prev_q      <= '0;
      duty_act_q  <= '0;
      duty_pend_q <= '0;
      err_val_q   <= '0;
      err_exp_q   <= '0;
      wrap_cnt_q  <= '0;
      pwm_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      duty_act_q  <= duty_act_d;
      duty_pend_q <= duty_pend_d;
      err_val_q   <= err_val_d;
      err_exp_q   <= err_exp_d;
      wrap_cnt_q  <= wrap_cnt_d;
      pwm_q       <= pwm_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end
  assign bus.pwm_out      = pwm_q;
  assign bus.wrap_pulse   = wrap_q;
  assign bus.wrap_count   = wrap_cnt_q;
  assign bus.step_error   = err_q;
  assign bus.err_value    = err_val_q;
  assign bus.err_expected = err_exp_q;
endmodule

// File: tb/tb_up_counter_monitor.sv
// tb_up_counter_monitor: directed checks on strict, hold-tolerant and 2-bit-tally monitors fed the same counter
module tb_up_counter_monitor;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt, duty;
  logic       ld, clr;
  int         total = 0;
  int         passed = 0;
  always #5 clk = ~clk;
  up_counter_if #(.CNT_W(4), .WRAP_W(8)) m_if ();
  up_counter_if #(.CNT_W(4), .WRAP_W(8)) h_if ();
  up_counter_if #(.CNT_W(4), .WRAP_W(2)) s_if ();
  assign m_if.counter = cnt;
  assign m_if.duty_in = duty;
  assign m_if.duty_load = ld;
  assign m_if.err_clear = clr;
  assign h_if.counter = cnt;
  assign h_if.duty_in = duty;
  assign h_if.duty_load = ld;
  assign h_if.err_clear = clr;
  assign s_if.counter = cnt;
  assign s_if.duty_in = duty;
  assign s_if.duty_load = ld;
  assign s_if.err_clear = clr;
  up_counter_monitor #(.CNT_W(4), .WRAP_W(8), .ALLOW_HOLD(1'b0)) u_m (.clk(clk), .reset(rst), .bus(m_if));
  up_counter_monitor #(.CNT_W(4), .WRAP_W(8), .ALLOW_HOLD(1'b1)) u_h (.clk(clk), .reset(rst), .bus(h_if));
  up_counter_monitor #(.CNT_W(4), .WRAP_W(2), .ALLOW_HOLD(1'b0)) u_s (.clk(clk), .reset(rst), .bus(s_if));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  // present one counter sample from a falling edge; returns at the next falling edge with its result visible
  task automatic drive(input int v, input bit l = 1'b0, input int d = 0, input bit c = 1'b0);
    cnt  = 4'(v);
    ld   = l;
    duty = 4'(d);
    clr  = c;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; cnt = '0; duty = '0; ld = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pwm", m_if.pwm_out, 0);
    chk("rst_wrap", m_if.wrap_pulse, 0);
    chk("rst_wcnt", m_if.wrap_count, 0);
    chk("rst_err", m_if.step_error, 0);
    chk("rst_errval", m_if.err_value, 0);
    chk("rst_errexp", m_if.err_expected, 0);
    rst = 1'b0;
    drive(0);
    for (int i = 1; i <= 48; i++) begin
      drive(i % 16);
      chk("run_wrap", m_if.wrap_pulse, (i % 16 == 0) ? 1 : 0);
      if (i == 20) chk("run_pwm0", m_if.pwm_out, 0);
    end
    chk("run_err", m_if.step_error, 0);
    chk("run_wcnt3", m_if.wrap_count, 3);
    chk("sat_wcnt3", s_if.wrap_count, 3);
    for (int i = 49; i <= 100; i++) begin
      int v;
      int exp_pwm;
      v = i % 16;
      if (i == 55) drive(v, 1'b1, 4);
      else if (i == 80) drive(v, 1'b1, 12);
      else if (i == 85) drive(v, 1'b1, 2);
      else if (i == 90) drive(v, 1'b1, 9);
      else drive(v);
      exp_pwm = (i < 64) ? 0 : (i < 96) ? int'(v < 4) : int'(v < 9);
      chk("pwm", m_if.pwm_out, exp_pwm);
      if (i == 64) chk("sat_hold", s_if.wrap_count, 3);
    end
    chk("pwm_wcnt6", m_if.wrap_count, 6);
    chk("sat_wcnt", s_if.wrap_count, 3);
    drive(5);
    drive(6);
    drive(6);
    chk("hold_err", m_if.step_error, 1);
    chk("hold_val", m_if.err_value, 6);
    chk("hold_exp", m_if.err_expected, 7);
    chk("hold_ok_err", h_if.step_error, 0);
    drive(6);
    chk("hold_ok_err2", h_if.step_error, 0);
    drive(7);
    chk("hold_ok_err3", h_if.step_error, 0);
    chk("hold_ok_wcnt", h_if.wrap_count, 6);
    chk("hold_ok_wrap", h_if.wrap_pulse, 0);
    chk("hold_frozen", m_if.err_value, 6);
    drive(8, 1'b0, 0, 1'b1);
    chk("clr_err", m_if.step_error, 0);
    chk("clr_wcnt", m_if.wrap_count, 0);
    chk("clr_keepval", m_if.err_value, 6);
    chk("clr_keepexp", m_if.err_expected, 7);
    drive(9);
    chk("sync_wrap", m_if.wrap_pulse, 0);
    for (int v = 10; v <= 15; v++) begin
      drive(v);
      chk("resume_err", m_if.step_error, 0);
    end
    drive(0);
    chk("resume_wrap", m_if.wrap_pulse, 1);
    chk("resume_wcnt", m_if.wrap_count, 1);
    chk("resume_pwm", m_if.pwm_out, 1);
    for (int v = 1; v <= 5; v++) drive(v);
    chk("pre_jump_pwm", m_if.pwm_out, 1);
    chk("pre_jump_err", m_if.step_error, 0);
    drive(9);
    chk("jump_err", m_if.step_error, 1);
    chk("jump_val", m_if.err_value, 9);
    chk("jump_exp", m_if.err_expected, 6);
    chk("jump_pwm", m_if.pwm_out, 0);
    chk("jump_h_err", h_if.step_error, 1);
    drive(2);
    chk("fault_val", m_if.err_value, 9);
    chk("fault_exp", m_if.err_expected, 6);
    chk("fault_pwm", m_if.pwm_out, 0);
    chk("fault_err", m_if.step_error, 1);
    rst = 1'b1;
    drive(3);
    chk("mid_rst_err", m_if.step_error, 0);
    chk("mid_rst_val", m_if.err_value, 0);
    chk("mid_rst_exp", m_if.err_expected, 0);
    chk("mid_rst_wcnt", m_if.wrap_count, 0);
    chk("mid_rst_pwm", m_if.pwm_out, 0);
    chk("mid_rst_wrap", m_if.wrap_pulse, 0);
    chk("mid_rst_sat", s_if.wrap_count, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
